// File: rtl/mips_isa_pkg.sv
// MIPS opcode/func fields shared with the control decoder, plus the request
// kind codes understood by instr_encoder.
package mips_isa_pkg;

    localparam logic [5:0] OP_RTYPE  = 6'b000000;
    localparam logic [5:0] OP_LW     = 6'b100011;
    localparam logic [5:0] OP_SW     = 6'b101011;
    localparam logic [5:0] OP_BEQ    = 6'b000100;
    localparam logic [5:0] OP_LUI    = 6'b001111;
    localparam logic [5:0] OP_ORI    = 6'b001101;
    localparam logic [5:0] OP_JAL    = 6'b000011;

    localparam logic [5:0] FUNC_ADDU = 6'b100001;
    localparam logic [5:0] FUNC_SUBU = 6'b100011;
    localparam logic [5:0] FUNC_JR   = 6'b001000;

    localparam logic [3:0] KIND_ADDU = 4'd0;
    localparam logic [3:0] KIND_SUBU = 4'd1;
    localparam logic [3:0] KIND_JR   = 4'd2;
    localparam logic [3:0] KIND_LW   = 4'd3;
    localparam logic [3:0] KIND_SW   = 4'd4;
    localparam logic [3:0] KIND_BEQ  = 4'd5;
    localparam logic [3:0] KIND_LUI  = 4'd6;
    localparam logic [3:0] KIND_ORI  = 4'd7;
    localparam logic [3:0] KIND_JAL  = 4'd8;
    localparam logic [3:0] KIND_LI   = 4'd9;
    localparam logic [3:0] KIND_NOP  = 4'd10;

    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    // Codes 11..15 are reserved and rejected by the encoder.
    function automatic logic kind_is_legal(input logic [3:0] kind);
        return kind <= KIND_NOP;
    endfunction

endpackage

// File: rtl/instr_word_fmt.sv
// Combinational packer: builds the 32-bit R/I/J-format word for one request
// kind. LI never arrives here directly; the encoder splits it into LUI/ORI.
module instr_word_fmt
    import mips_isa_pkg::*;
(
    input  logic [3:0]  kind,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [27:0] imm,
    output logic [31:0] word
);

    always_comb begin
        word = NOP_WORD;
        case (kind)
            KIND_ADDU: word = {OP_RTYPE, rs, rt, rd, 5'd0, FUNC_ADDU};
            KIND_SUBU: word = {OP_RTYPE, rs, rt, rd, 5'd0, FUNC_SUBU};
            KIND_JR:   word = {OP_RTYPE, rs, 5'd0, 5'd0, 5'd0, FUNC_JR};
            KIND_LW:   word = {OP_LW,  rs, rt, imm[15:0]};
            KIND_SW:   word = {OP_SW,  rs, rt, imm[15:0]};
            KIND_BEQ:  word = {OP_BEQ, rs, rt, imm[15:0]};
            KIND_LUI:  word = {OP_LUI, 5'd0, rt, imm[15:0]};
            KIND_ORI:  word = {OP_ORI, rs, rt, imm[15:0]};
            // JAL takes a byte target; the word index drops the low two bits
            KIND_JAL:  word = {OP_JAL, imm[27:2]};
            default:   word = NOP_WORD;
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Request-to-IM encoder: emits encoded MIPS words at a sequential address and
// expands li into lui+ori. Optional macro LI_SHORT_EN collapses li to one word.
module instr_encoder
    import mips_isa_pkg::*;
#(
    parameter int          ADDR_W    = 10,
    parameter logic [31:0] BASE_ADDR = 32'h0000_3000
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        req_kind,
    input  logic [4:0]        req_rs,
    input  logic [4:0]        req_rt,
    input  logic [4:0]        req_rd,
    input  logic [31:0]       req_imm,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
    output logic [31:0]       pc_next,
    output logic              full,
    output logic              err
);

    typedef enum logic {ST_IDLE, ST_LI_LO} state_e;

    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] ONE   = {{ADDR_W{1'b0}}, 1'b1};

    state_e          state, next_state;
    logic [ADDR_W:0] write_index;
    logic [4:0]      li_rt;
    logic [15:0]     li_lo;

    logic [3:0]  fmt_kind;
    logic [4:0]  fmt_rs, fmt_rt, fmt_rd;
    logic [27:0] fmt_imm;
    logic [31:0] fmt_word;
    logic        emit, set_err, latch_li, xfer;

    // The extra top bit of write_index lets full be seen without wrapping.
    assign full      = (write_index == DEPTH);
    assign req_ready = reset_n && (state == ST_IDLE) && !full;
    assign xfer      = req_valid && req_ready;
    assign pc_next   = BASE_ADDR + {{(29 - ADDR_W){1'b0}}, write_index, 2'b00};

    instr_word_fmt u_fmt (
        .kind (fmt_kind),
        .rs   (fmt_rs),
        .rt   (fmt_rt),
        .rd   (fmt_rd),
        .imm  (fmt_imm),
        .word (fmt_word)
    );

    always_comb begin
        next_state = state;
        fmt_kind   = req_kind;
        fmt_rs     = req_rs;
        fmt_rt     = req_rt;
        fmt_rd     = req_rd;
        fmt_imm    = req_imm[27:0];
        emit       = 1'b0;
        set_err    = 1'b0;
        latch_li   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (xfer) begin
                    if (!kind_is_legal(req_kind)) begin
                        set_err = 1'b1;
                    end else if (req_kind == KIND_LI) begin
                        emit     = 1'b1;
                        fmt_kind = KIND_LUI;
                        fmt_imm  = {12'h000, req_imm[31:16]};
`ifdef LI_SHORT_EN
                        if (req_imm[31:16] == 16'h0000) begin
                            fmt_kind = KIND_ORI;
                            fmt_rs   = 5'd0;
                            fmt_imm  = {12'h000, req_imm[15:0]};
                        end else if (req_imm[15:0] != 16'h0000) begin
                            latch_li   = 1'b1;
                            next_state = ST_LI_LO;
                        end
`else
                        latch_li   = 1'b1;
                        next_state = ST_LI_LO;
`endif
                    end else begin
                        emit = 1'b1;
                    end
                end
            end
            ST_LI_LO: begin
                // Second half of li; if the lui took the last slot it is lost.
                fmt_kind   = KIND_ORI;
                fmt_rs     = li_rt;
                fmt_rt     = li_rt;
                fmt_imm    = {12'h000, li_lo};
                next_state = ST_IDLE;
                if (full) begin
                    set_err = 1'b1;
                end else begin
                    emit = 1'b1;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            write_index <= '0;
            im_we       <= 1'b0;
            im_addr     <= '0;
            im_wdata    <= '0;
            err         <= 1'b0;
            li_rt       <= '0;
            li_lo       <= '0;
        end else begin
            im_we <= emit;
            if (emit) begin
                im_addr     <= write_index[ADDR_W-1:0];
                im_wdata    <= fmt_word;
                write_index <= write_index + ONE;
            end
            if (set_err) begin
                err <= 1'b1;
            end
            if (latch_li) begin
                li_rt <= req_rt;
                li_lo <= req_imm[15:0];
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder (ADDR_W=2): directed cases plus random
// request episodes checked against a queue-based reference model.
module tb_instr_encoder;

    localparam int ADDR_W = 2;
    localparam int DEPTH  = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [3:0]  req_kind = '0;
    logic [4:0]  req_rs = '0;
    logic [4:0]  req_rt = '0;
    logic [4:0]  req_rd = '0;
    logic [31:0] req_imm = '0;
    logic        im_we;
    logic [ADDR_W-1:0] im_addr;
    logic [31:0] im_wdata;
    logic [31:0] pc_next;
    logic        full;
    logic        err;

    instr_encoder #(.ADDR_W(ADDR_W), .BASE_ADDR(32'h0000_3000)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_kind  (req_kind),
        .req_rs    (req_rs),
        .req_rt    (req_rt),
        .req_rd    (req_rd),
        .req_imm   (req_imm),
        .im_we     (im_we),
        .im_addr   (im_addr),
        .im_wdata  (im_wdata),
        .pc_next   (pc_next),
        .full      (full),
        .err       (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int check_count = 0;
    int error_count = 0;

    typedef struct {
        int          cyc;
        logic [1:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t expq[$];
    int  m_index = 0;
    bit  m_err = 1'b0;
    int  li_busy_cyc = -1;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", tag, actual, expected, cyc);
        end
    endtask

    function automatic logic [31:0] enc_r(input logic [31:0] rs, rt, rd, fn);
        return (rs << 21) | (rt << 16) | (rd << 11) | fn;
    endfunction

    function automatic logic [31:0] enc_i(input logic [31:0] op, rs, rt, imm);
        return (op << 26) | (rs << 21) | (rt << 16) | (imm & 32'h0000_FFFF);
    endfunction

    function automatic bit push_word(input logic [31:0] data, input int at_cyc);
        wr_t w;
        if (m_index >= DEPTH) return 1'b0;
        w.cyc  = at_cyc;
        w.addr = 2'(m_index);
        w.data = data;
        expq.push_back(w);
        m_index++;
        return 1'b1;
    endfunction

    function automatic logic expect_ready();
        return reset_n && (m_index < DEPTH) && (cyc != li_busy_cyc);
    endfunction

    // Reference model: what an accepted request should write, and when.
    task automatic modelAccept(input logic [3:0] k, input logic [4:0] rs, rt, rd,
                               input logic [31:0] imm, input int c);
        logic [31:0] hi, lo;
        bit ok;
        hi = imm >> 16;
        lo = imm & 32'h0000_FFFF;
        ok = 1'b1;
        case (k)
            4'd0:  ok = push_word(enc_r(32'(rs), 32'(rt), 32'(rd), 33), c);
            4'd1:  ok = push_word(enc_r(32'(rs), 32'(rt), 32'(rd), 35), c);
            4'd2:  ok = push_word(enc_r(32'(rs), 0, 0, 8), c);
            4'd3:  ok = push_word(enc_i(35, 32'(rs), 32'(rt), imm), c);
            4'd4:  ok = push_word(enc_i(43, 32'(rs), 32'(rt), imm), c);
            4'd5:  ok = push_word(enc_i(4, 32'(rs), 32'(rt), imm), c);
            4'd6:  ok = push_word(enc_i(15, 0, 32'(rt), imm), c);
            4'd7:  ok = push_word(enc_i(13, 32'(rs), 32'(rt), imm), c);
            4'd8:  ok = push_word((32'd3 << 26) | ((imm >> 2) & 32'h03FF_FFFF), c);
            4'd9: begin
`ifdef LI_SHORT_EN
                if (hi == 0) begin
                    ok = push_word(enc_i(13, 0, 32'(rt), lo), c);
                end else if (lo == 0) begin
                    ok = push_word(enc_i(15, 0, 32'(rt), hi), c);
                end else begin
                    ok = push_word(enc_i(15, 0, 32'(rt), hi), c);
                    li_busy_cyc = c;
                    if (!push_word(enc_i(13, 32'(rt), 32'(rt), lo), c + 1)) m_err = 1'b1;
                end
`else
                ok = push_word(enc_i(15, 0, 32'(rt), hi), c);
                li_busy_cyc = c;
                if (!push_word(enc_i(13, 32'(rt), 32'(rt), lo), c + 1)) m_err = 1'b1;
`endif
            end
            4'd10: ok = push_word(32'h0, c);
            default: m_err = 1'b1;
        endcase
        if (!ok) m_err = 1'b1;
    endtask

    task automatic checkState();
        checkOutput("full", 32'(full), 32'(m_index == DEPTH));
        checkOutput("err", 32'(err), 32'(m_err));
        checkOutput("pc_next", pc_next, 32'h0000_3000 + 32'(4 * m_index));
    endtask

    // Write monitor: every cycle either the expected word or no write.
    always @(negedge clk) begin
        if (expq.size() > 0 && expq[0].cyc == cyc) begin
            checkOutput("im_we", 32'(im_we), 32'd1);
            checkOutput("im_addr", 32'(im_addr), 32'(expq[0].addr));
            checkOutput("im_wdata", im_wdata, expq[0].data);
            void'(expq.pop_front());
        end else begin
            checkOutput("im_we_idle", 32'(im_we), 32'd0);
        end
    end

    task automatic applyStimulus(input logic [3:0] k, input logic [4:0] rs, rt, rd,
                                 input logic [31:0] imm, output bit accepted);
        int c;
        accepted = 1'b0;
        @(negedge clk);
        if (cyc != li_busy_cyc) checkState();
        req_kind  = k;
        req_rs    = rs;
        req_rt    = rt;
        req_rd    = rd;
        req_imm   = imm;
        req_valid = 1'b1;
        for (int w = 0; w < 8; w++) begin
            checkOutput("req_ready", 32'(req_ready), 32'(expect_ready()));
            if (req_ready) break;
            if (m_index >= DEPTH && w >= 3) break;
            @(negedge clk);
        end
        if (req_ready) begin
            accepted = 1'b1;
            c = cyc + 1;
            @(posedge clk);
            modelAccept(k, rs, rt, rd, imm, c);
            #1 req_valid = 1'b0;
        end else begin
            if (m_index < DEPTH) checkOutput("ready_timeout", 32'(req_ready), 32'd1);
            req_valid = 1'b0;
        end
    endtask

    task automatic resetDut();
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        expq.delete();
        m_index = 0;
        m_err = 1'b0;
        li_busy_cyc = -1;
        #1;
        checkOutput("rst_im_we", 32'(im_we), 32'd0);
        checkOutput("rst_im_addr", 32'(im_addr), 32'd0);
        checkOutput("rst_im_wdata", im_wdata, 32'd0);
        checkOutput("rst_err", 32'(err), 32'd0);
        checkOutput("rst_full", 32'(full), 32'd0);
        checkOutput("rst_ready", 32'(req_ready), 32'd0);
        checkOutput("rst_pc_next", pc_next, 32'h0000_3000);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit acc;
        logic [3:0]  k;
        logic [31:0] imm;
        int sel, n;

        resetDut();

        // ADDU, then a full li, then JAL on a fresh image
        applyStimulus(4'd0, 5'd1, 5'd2, 5'd3, 32'h0, acc);
        @(negedge clk);
        checkOutput("addu_word", im_wdata, 32'h0022_1821);
        checkOutput("addu_addr", 32'(im_addr), 32'd0);
        checkOutput("addu_pc_next", pc_next, 32'h0000_3004);

        resetDut();
        applyStimulus(4'd9, 5'd0, 5'd8, 5'd0, 32'h1234_5678, acc);
        @(negedge clk);
        checkOutput("li_lui_word", im_wdata, 32'h3C08_1234);
        checkOutput("li_bubble_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        checkOutput("li_ori_word", im_wdata, 32'h3508_5678);
        checkOutput("li_ori_addr", 32'(im_addr), 32'd1);
        checkOutput("li_after_ready", 32'(req_ready), 32'd1);

        applyStimulus(4'd8, 5'd0, 5'd0, 5'd0, 32'h0000_3008, acc);
        @(negedge clk);
        checkOutput("jal_word", im_wdata, 32'h0C00_0C02);

        // Fill the image, then a fifth request must be held off
        resetDut();
        repeat (4) applyStimulus(4'd10, 5'd0, 5'd0, 5'd0, 32'h0, acc);
        @(negedge clk);
        checkOutput("fill_full", 32'(full), 32'd1);
        checkOutput("fill_ready", 32'(req_ready), 32'd0);
        applyStimulus(4'd0, 5'd4, 5'd5, 5'd6, 32'h0, acc);
        checkOutput("fifth_held", 32'(acc), 32'd0);
        checkOutput("fill_pc_next", pc_next, 32'h0000_3010);

        // li into the last free slot loses its ori half
        resetDut();
        repeat (3) applyStimulus(4'd10, 5'd0, 5'd0, 5'd0, 32'h0, acc);
        applyStimulus(4'd9, 5'd0, 5'd8, 5'd0, 32'h1234_5678, acc);
        @(negedge clk);
        checkOutput("lastslot_lui", im_wdata, 32'h3C08_1234);
        checkOutput("lastslot_addr", 32'(im_addr), 32'd3);
        @(negedge clk);
        checkOutput("lastslot_no_we", 32'(im_we), 32'd0);
        checkOutput("lastslot_err", 32'(err), 32'd1);
        checkOutput("lastslot_full", 32'(full), 32'd1);

        // Illegal kind is consumed without a write
        resetDut();
        applyStimulus(4'hF, 5'd1, 5'd1, 5'd1, 32'hFFFF_FFFF, acc);
        checkOutput("illegal_accept", 32'(acc), 32'd1);
        @(negedge clk);
        checkOutput("illegal_no_we", 32'(im_we), 32'd0);
        checkOutput("illegal_err", 32'(err), 32'd1);
        checkOutput("illegal_pc_next", pc_next, 32'h0000_3000);

        // li with an all-zero upper half
        resetDut();
        applyStimulus(4'd9, 5'd0, 5'd9, 5'd0, 32'h0000_BEEF, acc);
        @(negedge clk);
`ifdef LI_SHORT_EN
        checkOutput("short_li_word", im_wdata, 32'h3409_BEEF);
        @(negedge clk);
        checkOutput("short_li_single", 32'(im_we), 32'd0);
`else
        checkOutput("li0_lui_word", im_wdata, 32'h3C09_0000);
        @(negedge clk);
        checkOutput("li0_ori_word", im_wdata, 32'h3529_BEEF);
`endif

        // Reset while the ori is pending: nothing more may be written
        resetDut();
        applyStimulus(4'd9, 5'd0, 5'd9, 5'd0, 32'h1234_5678, acc);
        resetDut();
        @(negedge clk);
        checkOutput("abort_no_ori", 32'(im_we), 32'd0);
        checkOutput("abort_pc_next", pc_next, 32'h0000_3000);

        // Random episodes against the model
        for (int ep = 0; ep < 30; ep++) begin
            resetDut();
            n = $urandom_range(2, 7);
            for (int r = 0; r < n; r++) begin
                sel = $urandom_range(0, 21);
                if (sel <= 10)      k = 4'(sel);
                else if (sel <= 17) k = 4'd9;
                else                k = 4'($urandom_range(11, 15));
                case ($urandom_range(0, 3))
                    0:       imm = {16'h0000, 16'($urandom)};
                    1:       imm = {16'($urandom), 16'h0000};
                    default: imm = $urandom;
                endcase
                applyStimulus(k, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                              5'($urandom_range(0, 31)), imm, acc);
                repeat ($urandom_range(0, 1)) @(negedge clk);
            end
            @(negedge clk);
            @(negedge clk);
            checkState();
        end

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", error_count, check_count);
        $finish;
    end

endmodule
